multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main sequencer for the multicycle RISC-V core. Time-shares one ALU, one memory port and the
//  register file across FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps. Drives ALU_Op_o into ALU_Control
//  plus all mux selects and write enables. Waits on a memory ready handshake and traps hung memory.
// PARAMETERS
//  CNT_WIDTH   32  width of retired-instruction counter
//  WAIT_LIMIT  15  max consecutive cycles a memory access may wait before HALT
// PORTS
//  clk           in   1          system clock, rising edge
//  reset         in   1          asynchronous, active-high
//  opcode_i      in   7          instruction[6:0] from IR
//  zero_i        in   1          ALU zero flag
//  mem_ready_i   in   1          memory completes current access this cycle
//  PC_Write_o    out  1          PC load enable
//  IR_Write_o    out  1          IR / old-PC load enable
//  ALU_Src_A_o   out  2          00 PC, 01 old PC, 10 rs1
//  ALU_Src_B_o   out  2          00 rs2, 01 const 4, 10 immediate
//  ALU_Op_o      out  3          000 R, 001 I, 010 force ADD, 011 force SUB, 111 LUI
//  Reg_Write_o   out  1          register-file write enable
//  Mem_Read_o    out  1          memory read request
//  Mem_Write_o   out  1          memory write request
//  Result_Src_o  out  2          00 ALUOut reg, 01 mem data, 10 ALU result
//  illegal_o     out  1          one-cycle pulse: unsupported opcode decoded
//  error_o       out  1          sticky: memory wait timeout
//  retired_o     out  CNT_WIDTH  retired-instruction count
// BEHAVIOUR
//  - State reg async-reset to IDLE. Outputs are decoded from state (plus zero_i/mem_ready_i where noted).
//  - All outputs default 0 in every state unless listed. During reset: all 0, retired_o=0, error_o=0.
//  - IDLE: all outputs 0 -> FETCH next cycle.
//  - FETCH: A=00,B=01,Op=010,Mem_Read=1,Result_Src=10. IR_Write=PC_Write=mem_ready_i.
//    Transition: ready -> DECODE, else stay.
//  - DECODE: A=01,B=10,Op=010 (ALUOut <= branch/jump target). Next state by opcode:
//    0000011/0100011 MEM_ADDR; 0110011 EXEC_R; 0010011 EXEC_I; 0110111 LUI; 1100011 BRANCH;
//    1101111 JAL; other -> illegal_o=1 this cycle, FETCH, not counted.
//  - MEM_ADDR: A=10,B=10,Op=010. Load -> MEM_READ, store -> MEM_WRITE.
//  - MEM_READ: Mem_Read=1. Transition: ready -> MEM_WB.
//  - MEM_WB: Reg_Write=1,Result_Src=01 -> FETCH.
//  - MEM_WRITE: Mem_Write=1. Transition: ready -> FETCH.
//  - EXEC_R: A=10,B=00,Op=000. EXEC_I: A=10,B=10,Op=001. LUI: A=10,B=10,Op=111. All -> ALU_WB.
//  - ALU_WB: Reg_Write=1,Result_Src=00 -> FETCH.
//  - BRANCH (BEQ): A=10,B=00,Op=011,Result_Src=00,PC_Write=zero_i -> FETCH.
//  - JAL: A=01,B=01,Op=010,Result_Src=00,PC_Write=1 (PC<=target; ALUOut<=oldPC+4) -> ALU_WB.
//  - HALT: all enables 0, error_o=1. Exit only via reset.
//  - Wait timer (FETCH/MEM_READ/MEM_WRITE): clears on entry. Counts each cycle with mem_ready_i=0.
//    The WAIT_LIMIT-th consecutive low cycle -> HALT at next edge; error_o sets on that edge.
//    Ready high in that same cycle wins (normal transition, no error).
//  - retired_o: +1 on edge leaving MEM_WB, ALU_WB, BRANCH, or MEM_WRITE with ready.
//    JAL counts once (at its ALU_WB). Wraps modulo 2^CNT_WIDTH, no saturation.
//  - ALU_Control decodes Op 010 as ADD and 011 as SUB regardless of funct7/funct3.
//  - Reset mid-instruction: abandons state, next post-reset cycle is IDLE. No partial writes.
// STRUCTURE
//  - Shared include mc_control_defs.vh: state encodings (4-bit, 14 states), ALU_Op codes,
//    Src_A/Src_B/Result_Src select codes, opcode constants.
//  - Sub-module mem_wait_timer: clear/count inputs, WAIT_LIMIT parameter, timeout output.
//  - Top: state register, next-state logic, output decode, retired counter.
// TESTING
//  1 Reset, then ready=1 always, opcode=0110011 -> IDLE,FETCH,DECODE,EXEC_R,ALU_WB loop.
//    retired_o=1 after 5th cycle; Op=000 in EXEC_R.
//  2 LW with ready low 3 cycles in MEM_READ -> Mem_Read_o held 4 cycles; Reg_Write_o=1,
//    Result_Src_o=01 one cycle; no error.
//  3 BEQ, zero_i=1 -> PC_Write_o=1 in BRANCH; repeat with zero_i=0 -> PC_Write_o=0.
//    Both runs: retired +1.
//  4 opcode=1111111 -> illegal_o pulses in DECODE, next state FETCH, retired_o unchanged.
//  5 mem_ready_i=0 forever in FETCH -> HALT after 15 FETCH cycles, error_o=1 sticky.
//    Ready=1 exactly on cycle 15 -> DECODE, error_o=0.
//  6 JAL -> PC_Write_o=1,Result_Src_o=00 in JAL; then ALU_WB Reg_Write_o=1; retired +1.
//    Reset asserted mid-ALU_WB -> all outputs 0 immediately.
//    Preload retired=2^32-1 -> wraps to 0.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V control path: state codes, ALU op codes,
// datapath mux select codes and the opcodes the sequencer recognises.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_LUI       = 4'd9,
        S_ALU_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JAL       = 4'd12,
        S_HALT      = 4'd13
    } state_t;

    localparam logic [2:0] ALU_OP_R   = 3'b000;
    localparam logic [2:0] ALU_OP_I   = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b011;
    localparam logic [2:0] ALU_OP_LUI = 3'b111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // States that hold a memory access open and are therefore guarded by the wait timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Down-counter that flags the WAIT_LIMIT-th consecutive cycle a memory access is stalled.
// Reloaded on entry to each waiting state; terminal count is combinational.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= LOAD_VAL;
        end else if (i_clear) begin
            r_cnt <= LOAD_VAL;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Reaching zero while still stalled means this is the last tolerated low cycle.
    assign o_timeout = i_count && (r_cnt == '0);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle RISC-V core: state register, next-state/output decode,
// memory-wait watchdog and retired-instruction counter.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  IDLE        | post-reset bubble, all outputs idle
//  FETCH       | read instruction at PC, PC <= PC+4 when memory ready
//  DECODE      | ALUOut <= oldPC+imm (branch/jump target), dispatch on opcode
//  MEM_ADDR    | ALUOut <= rs1+imm (load/store address)
//  MEM_READ    | load data read, wait for ready
//  MEM_WB      | write loaded data to rd
//  MEM_WRITE   | store, wait for ready
//  EXEC_R      | R-type ALU operation
//  EXEC_I      | I-type ALU operation
//  LUI         | pass immediate through ALU
//  ALU_WB      | write ALUOut to rd
//  BRANCH      | BEQ compare, PC <= target when equal
//  JAL         | PC <= target, ALUOut <= oldPC+4
//  HALT        | memory timed out, frozen until reset
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 PC_Write_o,
    output logic                 IR_Write_o,
    output logic [1:0]           ALU_Src_A_o,
    output logic [1:0]           ALU_Src_B_o,
    output logic [2:0]           ALU_Op_o,
    output logic                 Reg_Write_o,
    output logic                 Mem_Read_o,
    output logic                 Mem_Write_o,
    output logic [1:0]           Result_Src_o,
    output logic                 illegal_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] retired_o
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_timeout;
    logic                   w_wait_clear;
    logic                   w_wait_count;
    logic                   w_retire;
    logic                   r_error;
    logic [CNT_WIDTH-1:0]   r_retired;

    assign w_wait_count = is_wait_state(r_state) && !mem_ready_i;
    assign w_wait_clear = is_wait_state(w_next) && (w_next != r_state);

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clear   (w_wait_clear),
        .i_count   (w_wait_count),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        PC_Write_o   = 1'b0;
        IR_Write_o   = 1'b0;
        ALU_Src_A_o  = SRC_A_PC;
        ALU_Src_B_o  = SRC_B_RS2;
        ALU_Op_o     = ALU_OP_R;
        Reg_Write_o  = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        Result_Src_o = RES_ALUOUT;
        illegal_o    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                ALU_Src_A_o  = SRC_A_PC;
                ALU_Src_B_o  = SRC_B_FOUR;
                ALU_Op_o     = ALU_OP_ADD;
                Mem_Read_o   = 1'b1;
                Result_Src_o = RES_ALU;
                IR_Write_o   = mem_ready_i;
                PC_Write_o   = mem_ready_i;
                if (mem_ready_i) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                ALU_Src_A_o = SRC_A_OLD_PC;
                ALU_Src_B_o = SRC_B_IMM;
                ALU_Op_o    = ALU_OP_ADD;
                case (opcode_i)
                    OPC_LOAD, OPC_STORE: w_next = S_MEM_ADDR;
                    OPC_RTYPE:           w_next = S_EXEC_R;
                    OPC_ITYPE:           w_next = S_EXEC_I;
                    OPC_LUI:             w_next = S_LUI;
                    OPC_BRANCH:          w_next = S_BRANCH;
                    OPC_JAL:             w_next = S_JAL;
                    default: begin
                        illegal_o = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = SRC_B_IMM;
                ALU_Op_o    = ALU_OP_ADD;
                w_next      = (opcode_i == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                Mem_Read_o = 1'b1;
                if (mem_ready_i) begin
                    w_next = S_MEM_WB;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Result_Src_o = RES_MEM;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                Mem_Write_o = 1'b1;
                if (mem_ready_i) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_EXEC_R: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = SRC_B_RS2;
                ALU_Op_o    = ALU_OP_R;
                w_next      = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = SRC_B_IMM;
                ALU_Op_o    = ALU_OP_I;
                w_next      = S_ALU_WB;
            end
            S_LUI: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = SRC_B_IMM;
                ALU_Op_o    = ALU_OP_LUI;
                w_next      = S_ALU_WB;
            end
            S_ALU_WB: begin
                Reg_Write_o  = 1'b1;
                Result_Src_o = RES_ALUOUT;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                ALU_Src_A_o  = SRC_A_RS1;
                ALU_Src_B_o  = SRC_B_RS2;
                ALU_Op_o     = ALU_OP_SUB;
                Result_Src_o = RES_ALUOUT;
                PC_Write_o   = zero_i;
                w_next       = S_FETCH;
            end
            S_JAL: begin
                // Target computed in DECODE is loaded now; ALU re-forms oldPC+4 as the link value.
                ALU_Src_A_o  = SRC_A_OLD_PC;
                ALU_Src_B_o  = SRC_B_FOUR;
                ALU_Op_o     = ALU_OP_ADD;
                Result_Src_o = RES_ALUOUT;
                PC_Write_o   = 1'b1;
                w_next       = S_ALU_WB;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_retire = (r_state == S_MEM_WB) || (r_state == S_ALU_WB) || (r_state == S_BRANCH)
                      || ((r_state == S_MEM_WRITE) && mem_ready_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
            r_error   <= 1'b0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign retired_o = r_retired;
    assign error_o   = r_error;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; a second narrow-counter instance shares all
// inputs so the retired counter's modulo wrap is visible within a short run.
module tb_multicycle_control_fsm;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        ready;

    logic        pc_w, ir_w, reg_w, mem_r, mem_w, ill, err;
    logic [1:0]  src_a, src_b, res_src;
    logic [2:0]  alu_op;
    logic [31:0] retired;

    logic        n_pc_w, n_ir_w, n_reg_w, n_mem_r, n_mem_w, n_ill, n_err;
    logic [1:0]  n_src_a, n_src_b, n_res_src;
    logic [2:0]  n_alu_op;
    logic [1:0]  n_retired;

    logic [15:0] cw_obs;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_control_fsm #(.CNT_WIDTH(32), .WAIT_LIMIT(15)) u_dut (
        .clk(clk), .reset(reset), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(ready),
        .PC_Write_o(pc_w), .IR_Write_o(ir_w), .ALU_Src_A_o(src_a), .ALU_Src_B_o(src_b),
        .ALU_Op_o(alu_op), .Reg_Write_o(reg_w), .Mem_Read_o(mem_r), .Mem_Write_o(mem_w),
        .Result_Src_o(res_src), .illegal_o(ill), .error_o(err), .retired_o(retired)
    );

    multicycle_control_fsm #(.CNT_WIDTH(2), .WAIT_LIMIT(15)) u_dut_w (
        .clk(clk), .reset(reset), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(ready),
        .PC_Write_o(n_pc_w), .IR_Write_o(n_ir_w), .ALU_Src_A_o(n_src_a), .ALU_Src_B_o(n_src_b),
        .ALU_Op_o(n_alu_op), .Reg_Write_o(n_reg_w), .Mem_Read_o(n_mem_r), .Mem_Write_o(n_mem_w),
        .Result_Src_o(n_res_src), .illegal_o(n_ill), .error_o(n_err), .retired_o(n_retired)
    );

    assign cw_obs = {pc_w, ir_w, src_a, src_b, alu_op, reg_w, mem_r, mem_w, res_src, ill, err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] cw(input logic pcw, input logic irw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [2:0] op, input logic rw,
                                       input logic mr, input logic mw, input logic [1:0] rs,
                                       input logic il, input logic er);
        return {pcw, irw, a, b, op, rw, mr, mw, rs, il, er};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    localparam logic [15:0] CW_ZERO   = 16'h0000;
    logic [15:0] cw_fetch_rdy, cw_fetch_wait, cw_decode, cw_decode_ill, cw_exec_r, cw_alu_wb;
    logic [15:0] cw_mem_addr, cw_mem_read, cw_mem_wb, cw_mem_write, cw_beq_t, cw_beq_nt;
    logic [15:0] cw_jal, cw_halt;

    initial begin
        cw_fetch_rdy  = cw(1, 1, 2'b00, 2'b01, 3'b010, 0, 1, 0, 2'b10, 0, 0);
        cw_fetch_wait = cw(0, 0, 2'b00, 2'b01, 3'b010, 0, 1, 0, 2'b10, 0, 0);
        cw_decode     = cw(0, 0, 2'b01, 2'b10, 3'b010, 0, 0, 0, 2'b00, 0, 0);
        cw_decode_ill = cw(0, 0, 2'b01, 2'b10, 3'b010, 0, 0, 0, 2'b00, 1, 0);
        cw_exec_r     = cw(0, 0, 2'b10, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 0);
        cw_alu_wb     = cw(0, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0, 2'b00, 0, 0);
        cw_mem_addr   = cw(0, 0, 2'b10, 2'b10, 3'b010, 0, 0, 0, 2'b00, 0, 0);
        cw_mem_read   = cw(0, 0, 2'b00, 2'b00, 3'b000, 0, 1, 0, 2'b00, 0, 0);
        cw_mem_wb     = cw(0, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0, 2'b01, 0, 0);
        cw_mem_write  = cw(0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 1, 2'b00, 0, 0);
        cw_beq_t      = cw(1, 0, 2'b10, 2'b00, 3'b011, 0, 0, 0, 2'b00, 0, 0);
        cw_beq_nt     = cw(0, 0, 2'b10, 2'b00, 3'b011, 0, 0, 0, 2'b00, 0, 0);
        cw_jal        = cw(1, 0, 2'b01, 2'b01, 3'b010, 0, 0, 0, 2'b00, 0, 0);
        cw_halt       = cw(0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0, 2'b00, 0, 1);

        reset  = 1'b1;
        ready  = 1'b1;
        zero   = 1'b0;
        opcode = 7'b0110011;
        #12;
        chk("rst_cw", cw_obs, CW_ZERO);
        chk("rst_retired", retired, 0);

        // R-type loop with memory always ready
        reset = 1'b0;
        #1;
        chk("idle_cw", cw_obs, CW_ZERO);
        tick(); chk("r_fetch", cw_obs, cw_fetch_rdy);
        tick(); chk("r_decode", cw_obs, cw_decode);
        tick(); chk("r_exec", cw_obs, cw_exec_r);
        tick(); chk("r_alu_wb", cw_obs, cw_alu_wb);
        chk("r_ret_before", retired, 0);
        tick(); chk("r_ret_after", retired, 1);
        chk("r_back_fetch", cw_obs, cw_fetch_rdy);

        // LW with three stalled MEM_READ cycles
        opcode = 7'b0000011;
        tick(); chk("lw_decode", cw_obs, cw_decode);
        tick(); chk("lw_mem_addr", cw_obs, cw_mem_addr);
        ready = 1'b0;
        tick(); chk("lw_mr1", cw_obs, cw_mem_read);
        tick(); chk("lw_mr2", cw_obs, cw_mem_read);
        tick(); chk("lw_mr3", cw_obs, cw_mem_read);
        ready = 1'b1;
        #1;     chk("lw_mr4", cw_obs, cw_mem_read);
        tick(); chk("lw_mem_wb", cw_obs, cw_mem_wb);
        tick(); chk("lw_fetch", cw_obs, cw_fetch_rdy);
        chk("lw_ret", retired, 2);

        // SW retires on the ready edge of MEM_WRITE
        opcode = 7'b0100011;
        tick(); tick();
        tick(); chk("sw_mem_write", cw_obs, cw_mem_write);
        tick(); chk("sw_ret", retired, 3);
        chk("sw_ret_narrow", n_retired, 3);

        // BEQ taken, then not taken
        opcode = 7'b1100011;
        zero   = 1'b1;
        tick(); tick(); chk("beq_taken", cw_obs, cw_beq_t);
        tick(); chk("beq_t_ret", retired, 4);
        chk("narrow_wrap", n_retired, 0);
        zero = 1'b0;
        tick(); tick(); chk("beq_not_taken", cw_obs, cw_beq_nt);
        tick(); chk("beq_nt_ret", retired, 5);
        chk("narrow_after_wrap", n_retired, 1);

        // Unsupported opcode
        opcode = 7'b1111111;
        tick(); chk("ill_decode", cw_obs, cw_decode_ill);
        tick(); chk("ill_fetch", cw_obs, cw_fetch_rdy);
        chk("ill_ret", retired, 5);

        // JAL, counted once at its ALU_WB
        opcode = 7'b1101111;
        tick(); chk("jal_decode", cw_obs, cw_decode);
        tick(); chk("jal_state", cw_obs, cw_jal);
        tick(); chk("jal_alu_wb", cw_obs, cw_alu_wb);
        chk("jal_ret_mid", retired, 5);
        tick(); chk("jal_ret", retired, 6);

        // Second JAL interrupted by reset during ALU_WB
        tick(); tick();
        tick(); chk("jal2_alu_wb", cw_obs, cw_alu_wb);
        reset = 1'b1;
        #1;
        chk("midrst_cw", cw_obs, CW_ZERO);
        chk("midrst_ret", retired, 0);

        // Memory never ready in FETCH: fifteen stalled cycles then HALT
        ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;     chk("to_idle", cw_obs, CW_ZERO);
        tick();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("to_fetch%0d", i + 1), cw_obs, cw_fetch_wait);
            tick();
        end
        chk("to_halt", cw_obs, cw_halt);
        tick(); tick();
        chk("to_halt_sticky", cw_obs, cw_halt);
        ready = 1'b1;
        tick(); chk("to_halt_no_exit", cw_obs, cw_halt);

        // Ready on the fifteenth stalled cycle wins over the timeout
        reset = 1'b1;
        #1;     chk("to_err_cleared", cw_obs, CW_ZERO);
        ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("edge_fetch15", cw_obs, cw_fetch_wait);
        ready = 1'b1;
        #1;     chk("edge_fetch_rdy", cw_obs, cw_fetch_rdy);
        tick(); chk("edge_decode", cw_obs, cw_decode);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
